tt_um_unload: RTL

- Readback serializer for the ternary weight array. It is the reverse of the weight loader.
- On a start pulse it snapshots the flat weight vector. It then streams the vector out one MAX_IN_LEN-bit column per beat, in the exact order and bit mapping the loader used to write it.
- A valid/ready handshake carries the beats, with a last flag and a done pulse.
- Used for weight dump/verification paths and loader round-trip checks.

---
 rtl/tt_um_unload.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tt_um_unload.sv
// tt_um_unload: readback serializer for the ternary weight array.
// On a start pulse the flat weight vector is snapshotted. It is then streamed
// out one MAX_IN_LEN-bit column per beat, over a valid/ready handshake, in the
// same order and bit mapping the weight loader uses to write it.
//
//   state  | meaning
//   IDLE   | waiting for ui_start; outputs quiet
//   STREAM | presenting beat `count` until it is accepted
//   DONE   | one-cycle uo_done pulse, then back to IDLE
module tt_um_unload #(
    parameter int MAX_IN_LEN   = 16,
    parameter int MAX_OUT_LEN  = 8,
    parameter int WIDTH        = 2,
    parameter int MAX_IN_BITS  = $clog2(MAX_IN_LEN),
    parameter int MAX_OUT_BITS = $clog2(MAX_OUT_LEN),
    parameter int WIDTH_BITS   = $clog2(WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ena,
    input  logic                                ui_start,
    input  logic [MAX_IN_BITS+MAX_OUT_BITS-1:0] ui_param,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    input  logic                                ui_ready,
    output logic [MAX_IN_LEN-1:0]               uo_data,
    output logic                                uo_valid,
    output logic                                uo_last,
    output logic                                uo_busy,
    output logic                                uo_done
);

    localparam int CNT_W  = MAX_OUT_BITS + WIDTH_BITS;
    localparam int SNAP_W = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [MAX_OUT_BITS-1:0] len;
    logic [SNAP_W-1:0]       snap;
    logic [CNT_W-1:0]        last_count;
    logic                    accept;

    // Only the column-count field of ui_param is meaningful here.
    logic unused_param;
    assign unused_param = &{1'b0, ui_param[MAX_IN_BITS+MAX_OUT_BITS-1:MAX_OUT_BITS]};

    // Final beat index: every weight bit of the last configured column.
    assign last_count = {len, {WIDTH_BITS{1'b1}}};
    assign accept     = ena & uo_valid & ui_ready;

    // Sequencer: snapshot on start, advance on each accepted beat, pulse done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            len      <= '0;
            snap     <= '0;
            uo_valid <= 1'b0;
            uo_busy  <= 1'b0;
            uo_done  <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    uo_done <= 1'b0;
                    if (ui_start) begin
                        snap     <= ui_weights;
                        len      <= ui_param[MAX_OUT_BITS-1:0];
                        count    <= '0;
                        uo_valid <= 1'b1;
                        uo_busy  <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (count == last_count) begin
                            uo_valid <= 1'b0;
                            uo_busy  <= 1'b0;
                            uo_done  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    uo_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    uo_valid <= 1'b0;
                    uo_busy  <= 1'b0;
                    uo_done  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Column gather: row i of the beat is snapshot bit {i, count}, the loader's write index.
    always_comb begin
        logic [MAX_IN_BITS-1:0] row;
        row     = '0;
        uo_data = '0;
        for (int i = 0; i < MAX_IN_LEN; i++) begin
            row        = i[MAX_IN_BITS-1:0];
            uo_data[i] = snap[{row, count}];
        end
    end

    // Last flag is only meaningful while a beat is on offer.
    always_comb begin
        uo_last = (state == STREAM) && (count == last_count);
    end

endmodule
